// File: rtl/mio_responder.sv
// Memory/IO responder: word RAM plus LED/switch/counter page, fixed wait states, one-cycle ready pulse.
// Build option: define MIO_COUNTER_EN to include the free-running cycle counter at 0xF000_0008.
module mio_responder #(
    parameter int RAM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_out,
    input  logic [31:0] Data_out,
    input  logic [3:0]  wea,
    input  logic [15:0] sw_in,
    output logic        MIO_ready,
    output logic [31:0] Datain,
    output logic [15:0] led_out,
    output logic        bus_err,
    output logic [1:0]  dbg_state
);
    // Handshake: a request is accepted when CPU_MIO=1 is sampled in IDLE; it cannot be
    // cancelled, and MIO_ready pulses for exactly one cycle when the access has committed.
    localparam int AW = $clog2(RAM_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        req_w;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_wea;

    logic        cur_w;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    logic [3:0]  cur_wea;
    logic        commit;
    logic        is_ram, is_led, is_sw, is_cnt;
    logic [AW-1:0] ram_idx;
    logic [31:0] rd_data;
    logic [31:0] cnt_val;

    logic [31:0] ram [RAM_WORDS];

    assign dbg_state = state;

    // With zero wait states the access commits on the sampling edge itself, so use the live inputs.
    always_comb begin
        cur_w    = req_w;
        cur_addr = req_addr;
        cur_data = req_data;
        cur_wea  = req_wea;
        if (state == S_IDLE) begin
            cur_w    = mem_w;
            cur_addr = Addr_out;
            cur_data = Data_out;
            cur_wea  = wea;
        end
    end

    assign commit = ((state == S_IDLE) && CPU_MIO && (WAIT_CYCLES == 0)) ||
                    ((state == S_WAIT) && (wait_cnt == 4'd0));

    assign is_ram  = (cur_addr >> 2) < 32'(RAM_WORDS);
    assign is_led  = (cur_addr | 32'h3) == 32'hF000_0003;
    assign is_sw   = (cur_addr | 32'h3) == 32'hF000_0007;
    assign is_cnt  = (cur_addr | 32'h3) == 32'hF000_000B;
    assign ram_idx = cur_addr[AW+1:2];

    always_comb begin
        rd_data = 32'h0;
        if (is_ram)      rd_data = ram[ram_idx];
        else if (is_led) rd_data = {16'h0, led_out};
        else if (is_sw)  rd_data = {16'h0, sw_in};
        else if (is_cnt) rd_data = cnt_val;
    end

`ifdef MIO_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_cnt <= 32'h0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cnt_val = cycle_cnt;
`else
    assign cnt_val = 32'h0;
`endif

    // RAM is never reset; the reset gate keeps a zero-wait request from writing while held in reset.
    always_ff @(posedge clk) begin
        if (reset && commit && cur_w && is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wea[i]) ram[ram_idx][8*i +: 8] <= cur_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            req_w     <= 1'b0;
            req_addr  <= 32'h0;
            req_data  <= 32'h0;
            req_wea   <= 4'h0;
            MIO_ready <= 1'b0;
            Datain    <= 32'h0;
            led_out   <= 16'h0;
            bus_err   <= 1'b0;
        end else begin
            MIO_ready <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (CPU_MIO) begin
                        req_w    <= mem_w;
                        req_addr <= Addr_out;
                        req_data <= Data_out;
                        req_wea  <= wea;
                        if (WAIT_CYCLES == 0) begin
                            state     <= S_DONE;
                            MIO_ready <= 1'b1;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_DONE;
                        MIO_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (commit) begin
                if (cur_w) begin
                    if (is_led && cur_wea[0]) led_out[7:0]  <= cur_data[7:0];
                    if (is_led && cur_wea[1]) led_out[15:8] <= cur_data[15:8];
                end else begin
                    Datain <= rd_data;
                end
                if (!(is_ram || is_led || is_sw || is_cnt)) bus_err <= 1'b1;
            end
        end
    end
endmodule
